// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding, default bit period and frame geometry.
// Imported by uart_rx; uart_tx uses the same default bit period.
package uart_rx_pkg;

  // Roughly 4160 baud at a 4.16 MHz core clock.
  localparam int unsigned UART_CLOCKS_PER_BIT = 1000;
  localparam int unsigned UART_DATA_BITS      = 8;
  localparam int unsigned UART_BIT_IDX_W      = $clog2(UART_DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  // Bit timer width; never below one bit so tiny periods still elaborate.
  function automatic int unsigned timer_width(input int unsigned clocks_per_bit);
    return (clocks_per_bit < 2) ? 1 : $clog2(clocks_per_bit);
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling after a 2-flop synchronizer; o_rxValid rises 1 cycle after the stop sample.
// No backpressure: a byte finishing while the previous one is unread is dropped and flagged as overrun.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = UART_CLOCKS_PER_BIT
) (
  input  logic       i_clock,
  input  logic       i_resetN,
  input  logic       i_rxSerial,
  input  logic       i_rxRead,
  input  logic       i_errorClear,
  output logic [7:0] o_rxData,
  output logic       o_rxValid,
  output logic       o_rxBusy,
  output logic       o_frameError,
  output logic       o_overrunError
);

  localparam int unsigned TIMER_W = timer_width(CLOCKS_PER_BIT);
  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLOCKS_PER_BIT - 1);
  localparam logic [UART_BIT_IDX_W-1:0] LAST_BIT_IDX = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

  logic                      sync1_q;
  logic                      sync2_q;
  logic                      rx_s;

  uart_state_e               state_q;
  logic [TIMER_W-1:0]        timer_q;
  logic [UART_BIT_IDX_W-1:0] bit_idx_q;
  logic [7:0]                shift_q;

  logic [7:0]                data_q;
  logic [7:0]                data_d;
  logic                      valid_q;
  logic                      valid_d;
  logic                      frame_err_q;
  logic                      frame_err_d;
  logic                      overrun_q;
  logic                      overrun_d;

  logic                      stop_tick;
  logic                      accept;
  logic                      frame_bad;

  // Synchronizer resets to the idle level so reset release never looks like a start edge.
  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_rxSerial;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          timer_q   <= '0;
          bit_idx_q <= '0;
          if (!rx_s) begin
            state_q <= ST_START;
          end
        end

        ST_START: begin
          if (timer_q == HALF_LAST) begin
            timer_q <= '0;
            // A line back high at mid start bit was a glitch.
            state_q <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (timer_q == BIT_LAST) begin
            timer_q   <= '0;
            shift_q   <= {rx_s, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == LAST_BIT_IDX) begin
              state_q <= ST_STOP;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        ST_STOP: begin
          if (timer_q == BIT_LAST) begin
            timer_q <= '0;
            state_q <= rx_s ? ST_IDLE : ST_BREAK;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        ST_BREAK: begin
          timer_q <= '0;
          if (rx_s) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          timer_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign stop_tick = (state_q == ST_STOP) && (timer_q == BIT_LAST);
  assign accept    = stop_tick && rx_s;
  assign frame_bad = stop_tick && !rx_s;

  // Clears are applied before sets so a flag raised in the same cycle survives.
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;

    if (valid_q && i_rxRead) begin
      valid_d = 1'b0;
    end
    if (i_errorClear) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (accept) begin
      if (!valid_q || i_rxRead) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (frame_bad) begin
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_rxData       = data_q;
  assign o_rxValid      = valid_q;
  assign o_rxBusy       = (state_q != ST_IDLE);
  assign o_frameError   = frame_err_q;
  assign o_overrunError = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: event-based output model compared every cycle, plus directed literal checks.
// A second receiver at the default bit period checks back-to-back frames with +-2% baud offset.
module tb_uart_rx;

  localparam int C  = 16;
  localparam int H  = C / 2;
  localparam int CS = 1000;

  localparam int EV_ON   = 0;
  localparam int EV_OFF  = 1;
  localparam int EV_ACC  = 2;
  localparam int EV_FERR = 3;

  typedef struct {
    int         t;
    int         kind;
    logic [7:0] b;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       line;
  logic       rd;
  logic       clr;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_busy;
  logic       o_fe;
  logic       o_oe;

  logic       line_s;
  logic       rd_s;
  logic [7:0] data_s;
  logic       valid_s;
  logic       busy_s;
  logic       fe_s;
  logic       oe_s;

  int         cyc;
  int         total;
  int         bad;
  int         rise_cyc;
  int         last_k;
  logic       check_en;
  logic       rand_mode;
  logic       prev_v;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_busy;
  logic       m_fe;
  logic       m_oe;
  logic       v_old;
  ev_t        evq[$];
  logic [7:0] exp_s[$];

  uart_rx #(.CLOCKS_PER_BIT(C)) u_dut (
    .i_clock(clk), .i_resetN(rst_n), .i_rxSerial(line), .i_rxRead(rd),
    .i_errorClear(clr), .o_rxData(o_data), .o_rxValid(o_valid), .o_rxBusy(o_busy),
    .o_frameError(o_fe), .o_overrunError(o_oe)
  );

  uart_rx #(.CLOCKS_PER_BIT(CS)) u_dut_slow (
    .i_clock(clk), .i_resetN(rst_n), .i_rxSerial(line_s), .i_rxRead(rd_s),
    .i_errorClear(1'b0), .o_rxData(data_s), .o_rxValid(valid_s), .o_rxBusy(busy_s),
    .o_frameError(fe_s), .o_overrunError(oe_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int t, input int kind, input logic [7:0] b);
    evq.push_back('{t: t, kind: kind, b: b});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      rd  = ($urandom_range(0, 5) == 0);
      clr = ($urandom_range(0, 40) == 0);
    end
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  // Line falls after edge k; the frame decision lands at edge k + 3 (sync + idle detect)
  // + half a bit + 9 full bits.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic rd_acc);
    int k;
    int e;
    k = 0;
    e = 0;
    for (int t = 0; t < 10 * C; t++) begin
      tick();
      if (t == 0) begin
        k = cyc;
        e = k + 3 + H + 9 * C;
        push(k + 3, EV_ON, 8'h00);
        push(e, stop_ok ? EV_ACC : EV_FERR, b);
      end
      if (t / C == 0)      line = 1'b0;
      else if (t / C == 9) line = stop_ok;
      else                 line = b[t / C - 1];
      if (rd_acc) rd = (cyc == e - 1);
    end
    last_k = k;
  endtask

  task automatic line_high();
    tick();
    line = 1'b1;
    push(cyc + 3, EV_OFF, 8'h00);
  endtask

  task automatic glitch(input int len);
    int k;
    tick();
    line = 1'b0;
    k = cyc;
    push(k + 3, EV_ON, 8'h00);
    push(k + 3 + H, EV_OFF, 8'h00);
    repeat (len) tick();
    line = 1'b1;
    repeat (H + 4) tick();
  endtask

  task automatic send_slow(input logic [7:0] b, input int ctx);
    for (int t = 0; t < 10 * ctx; t++) begin
      tick();
      if (t == 0) exp_s.push_back(b);
      if (t / ctx == 0)      line_s = 1'b0;
      else if (t / ctx == 9) line_s = 1'b1;
      else                   line_s = b[t / ctx - 1];
    end
  endtask

  task automatic check_slow(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (valid_s !== 1'b1 && w < 20000);
      #1;
      chk("slow_valid", {31'd0, valid_s}, 1);
      if (valid_s === 1'b1 && exp_s.size() > 0) begin
        chk("slow_data", {24'd0, data_s}, {24'd0, exp_s.pop_front()});
        chk("slow_flags", {30'd0, fe_s, oe_s}, 0);
        tick();
        rd_s = 1'b1;
        tick();
        rd_s = 1'b0;
      end
    end
  endtask

  // Output model: applies read/clear rules every edge and the frame outcomes scheduled by the drivers.
  initial begin
    cyc     = 0;
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_busy  = 1'b0;
    m_fe    = 1'b0;
    m_oe    = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_busy  = 1'b0;
        m_fe    = 1'b0;
        m_oe    = 1'b0;
        evq.delete();
      end else begin
        v_old = m_valid;
        if (v_old && rd) m_valid = 1'b0;
        if (clr) begin
          m_fe = 1'b0;
          m_oe = 1'b0;
        end
        for (int i = evq.size() - 1; i >= 0; i--) begin
          if (evq[i].t == cyc) begin
            case (evq[i].kind)
              EV_ON:  m_busy = 1'b1;
              EV_OFF: m_busy = 1'b0;
              EV_ACC: begin
                m_busy = 1'b0;
                if (!v_old || rd) begin
                  m_data  = evq[i].b;
                  m_valid = 1'b1;
                end else begin
                  m_oe = 1'b1;
                end
              end
              default: m_fe = 1'b1;
            endcase
            evq.delete(i);
          end
        end
      end
    end
  end

  initial begin
    logic [11:0] act_v;
    logic [11:0] exp_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (check_en) begin
        act_v = {o_data, o_valid, o_busy, o_fe, o_oe};
        exp_v = rst_n ? {m_data, m_valid, m_busy, m_fe, m_oe} : 12'h000;
        total++;
        if (act_v !== exp_v) begin
          bad++;
          $display("FAIL cycle_compare cyc=%0d got=%03h want=%03h", cyc, act_v, exp_v);
        end
        if (o_valid === 1'b1 && prev_v === 1'b0) rise_cyc = cyc;
        prev_v = o_valid;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] rb;
    rst_n = 1'b0; line = 1'b1; rd = 1'b0; clr = 1'b0;
    line_s = 1'b1; rd_s = 1'b0;
    rand_mode = 1'b0; check_en = 1'b0;
    total = 0; bad = 0; rise_cyc = 0; last_k = 0;

    tick();
    check_en = 1'b1;
    tick();
    samp();
    chk("reset_outputs", {20'd0, o_data, o_valid, o_busy, o_fe, o_oe}, 0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();

    // Frame 0xA5, then read clears valid on the next cycle.
    send_frame(8'hA5, 1'b1, 1'b0);
    samp();
    chk("a5_data", {24'd0, o_data}, 32'hA5);
    chk("a5_valid", {31'd0, o_valid}, 1);
    chk("a5_flags", {30'd0, o_fe, o_oe}, 0);
    chk("a5_latency", rise_cyc - last_k, 155);
    tick(); rd = 1'b1;
    tick(); rd = 1'b0;
    samp();
    chk("a5_read_clears", {31'd0, o_valid}, 0);

    // Short low pulse on an idle line is rejected silently.
    glitch(5);
    samp();
    chk("glitch_state", {29'd0, o_valid, o_busy, o_fe}, 0);

    // Low stop bit followed by a held-low line.
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) tick();
    samp();
    chk("break_flags", {29'd0, o_valid, o_busy, o_fe}, 3'b011);
    line_high();
    repeat (5) tick();
    samp();
    chk("break_exit_busy", {31'd0, o_busy}, 0);
    chk("break_fe_sticky", {31'd0, o_fe}, 1);
    send_frame(8'h55, 1'b1, 1'b0);
    samp();
    chk("after_break_data", {24'd0, o_data}, 32'h55);
    chk("after_break_valid", {31'd0, o_valid}, 1);
    tick(); rd = 1'b1; clr = 1'b1;
    tick(); rd = 1'b0; clr = 1'b0;
    samp();
    chk("clear_fe", {31'd0, o_fe}, 0);

    // Overrun, then the same pair with a read in the accept cycle.
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    samp();
    chk("overrun_data", {24'd0, o_data}, 32'h11);
    chk("overrun_flag", {31'd0, o_oe}, 1);
    tick(); rd = 1'b1; clr = 1'b1;
    tick(); rd = 1'b0; clr = 1'b0;
    repeat (2) tick();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1);
    samp();
    chk("read_at_accept_data", {24'd0, o_data}, 32'h22);
    chk("read_at_accept_no_oe", {31'd0, o_oe}, 0);
    send_frame(8'h44, 1'b1, 1'b0);
    samp();
    chk("overrun_keeps_old", {23'd0, o_data, o_oe}, {23'd0, 8'h22, 1'b1});

    // Reset in the middle of data bit 4 of a 0x0F frame.
    tick();
    line = 1'b0;
    push(cyc + 3, EV_ON, 8'h00);
    for (int t = 1; t < 5 * C + H; t++) begin
      tick();
      rb = 8'h0F;
      line = (t < C) ? 1'b0 : rb[t / C - 1];
    end
    tick();
    rst_n = 1'b0;
    line  = 1'b1;
    samp();
    chk("midframe_reset", {20'd0, o_data, o_valid, o_busy, o_fe, o_oe}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    send_frame(8'h81, 1'b1, 1'b0);
    samp();
    chk("post_reset_frame", {23'd0, o_data, o_valid}, {23'd0, 8'h81, 1'b1});
    tick(); rd = 1'b1;
    tick(); rd = 1'b0;

    // Randomized traffic: good frames, framing errors and glitches with random read/clear.
    rand_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        send_frame(8'($urandom), 1'b1, 1'b0);
      end else if (r < 8) begin
        send_frame(8'($urandom), 1'b0, 1'b0);
        repeat ($urandom_range(0, 30)) tick();
        line_high();
        repeat (2) tick();
      end else begin
        glitch($urandom_range(1, H - 1));
      end
      repeat ($urandom_range(0, 12)) tick();
    end
    rand_mode = 1'b0;
    tick();
    tick();
    rd = 1'b0;
    clr = 1'b0;
    repeat (4) tick();

    // Back-to-back frames at the default bit period, transmitter 2% slow then 2% fast.
    fork
      begin
        send_slow(8'hC3, 1020);
        send_slow(8'h5A, 1020);
        send_slow(8'h0F, 980);
        send_slow(8'hE1, 980);
      end
      check_slow(4);
    join
    repeat (20) tick();
    samp();
    chk("slow_idle", {29'd0, busy_s, fe_s, oe_s}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
